// File: rtl/spi_slave_datapath_param.sv
// SPI slave datapath: runtime word length, selectable bit order, multi-word bursts, valid/ready TX/RX.
// Optional sticky rx_overrun flag is enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave_datapath_param #(
  parameter int SPI_MAX_WIDTH_LOG = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cpha,
  input  logic                                lsb_first,
  input  logic [SPI_MAX_WIDTH_LOG-1:0]        len,
  input  logic                                spi_start,
  input  logic                                spi_stop,
  input  logic                                sck_first_edge,
  input  logic                                sck_second_edge,
  input  logic                                mosi,
  output logic                                miso,
  input  logic [(1<<SPI_MAX_WIDTH_LOG)-1:0]   tx_data,
  input  logic                                tx_valid,
  output logic                                tx_ready,
  output logic [(1<<SPI_MAX_WIDTH_LOG)-1:0]   rx_data,
  output logic                                rx_valid,
  input  logic                                rx_ready,
  output logic                                busy,
  output logic                                underrun
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic                                rx_overrun
`endif
);

  localparam int W  = 1 << SPI_MAX_WIDTH_LOG;
  localparam int CW = SPI_MAX_WIDTH_LOG + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                       state, state_next;
  logic                         lsb_q;
  logic [SPI_MAX_WIDTH_LOG-1:0] len_q;
  logic [W-1:0]                 tx_hold;
  logic                         tx_full;
  logic [W-1:0]                 tx_shift;
  logic [W-1:0]                 rx_shift;
  logic [W-1:0]                 rx_next;
  logic [CW-1:0]                bit_cnt;
  logic [CW-1:0]                cnt_inc;
  logic [CW-1:0]                len_end;
  logic                         edge_ok;
  logic                         rd_evt;
  logic                         wr_evt;
  logic                         done;
  logic                         load;
  logic                         tx_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (spi_start)     state_next = ACTIVE;
    else if (spi_stop) state_next = IDLE;
  end

  // Edge roles swap with cpha; a simultaneous second edge is dropped in favour of the first.
  always_comb begin
    edge_ok   = (state == ACTIVE) && !spi_start && !spi_stop;
    rd_evt    = edge_ok && (cpha ? (sck_second_edge && !sck_first_edge) : sck_first_edge);
    wr_evt    = edge_ok && (cpha ? sck_first_edge : (sck_second_edge && !sck_first_edge));
    cnt_inc   = bit_cnt + CW'(1);
    len_end   = {1'b0, len_q} + CW'(1);
    done      = rd_evt && (cnt_inc == len_end);
    load      = spi_start || done;
    tx_accept = tx_valid && !tx_full;
  end

  always_comb begin
    rx_next = rx_shift;
    if (lsb_q) rx_next[bit_cnt[SPI_MAX_WIDTH_LOG-1:0]] = mosi;
    else       rx_next = {rx_shift[W-2:0], mosi};
  end

  // TX path: holding register feeds the shifter at every word boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_hold  <= '0;
      tx_full  <= 1'b0;
      tx_shift <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= load && !tx_full && !tx_accept;
      if (load) begin
        if (tx_full) begin
          tx_shift <= tx_hold;
          tx_full  <= 1'b0;
        end else if (tx_accept) begin
          tx_shift <= tx_data;
        end else begin
          tx_shift <= '0;
        end
      end else begin
        if (tx_accept) begin
          tx_hold <= tx_data;
          tx_full <= 1'b1;
        end
        if (spi_stop)
          tx_shift <= '0;
        else if (wr_evt && (bit_cnt != '0))
          tx_shift <= lsb_q ? (tx_shift >> 1) : (tx_shift << 1);
      end
    end
  end

  // RX path and per-transfer configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsb_q    <= 1'b0;
      len_q    <= '0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (spi_start) begin
        lsb_q <= lsb_first;
        len_q <= len;
      end
      if (spi_start || spi_stop || done) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (rd_evt) begin
        bit_cnt  <= cnt_inc;
        rx_shift <= rx_next;
      end
      if (done) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  rx_overrun <= 1'b0;
    else if (spi_start)                       rx_overrun <= 1'b0;
    else if (done && rx_valid && !rx_ready)   rx_overrun <= 1'b1;
  end
`endif

  assign tx_ready = ~tx_full;
  assign busy     = (state == ACTIVE);
  assign miso     = (state == ACTIVE) ? (lsb_q ? tx_shift[0] : tx_shift[len_q]) : 1'b0;

endmodule

// File: tb/tb_spi_slave_datapath_param.sv
// Self-checking bench for spi_slave_datapath_param: word-level model plus directed literal checks.
module tb_spi_slave_datapath_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpha = 1'b0;
  logic        lsb_first = 1'b0;
  logic [3:0]  len = 4'd7;
  logic        spi_start = 1'b0;
  logic        spi_stop = 1'b0;
  logic        sck_first_edge = 1'b0;
  logic        sck_second_edge = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        busy;
  logic        underrun;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic        rx_overrun;
`endif

  spi_slave_datapath_param #(.SPI_MAX_WIDTH_LOG(4)) dut (
    .clk(clk), .rst(rst), .cpha(cpha), .lsb_first(lsb_first), .len(len),
    .spi_start(spi_start), .spi_stop(spi_stop),
    .sck_first_edge(sck_first_edge), .sck_second_edge(sck_second_edge),
    .mosi(mosi), .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .underrun(underrun)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .rx_overrun(rx_overrun)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int u_cnt = 0;
  int rv_cnt = 0;

  // Word-level model of the slave as seen from its pins.
  logic        m_active = 1'b0;
  logic        m_lsb = 1'b0;
  int          m_len = 0;
  logic [15:0] m_cur = '0;
  int          m_bit = 0;
  logic [15:0] m_hold[$];
  logic [15:0] m_rx_data = '0;
  logic        m_rx_valid = 1'b0;
  logic        m_underrun = 1'b0;
  logic        m_overrun = 1'b0;

  logic        ev_start = 1'b0;
  logic        ev_stop = 1'b0;
  logic        ev_load = 1'b0;
  logic        ev_done = 1'b0;
  logic [15:0] ev_word = '0;

  function automatic logic exp_miso();
    int idx;
    if (!m_active) return 1'b0;
    idx = m_lsb ? m_bit : (m_len - m_bit);
    return m_cur[idx];
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("miso", {15'd0, miso}, {15'd0, exp_miso()});
    checkOutput("busy", {15'd0, busy}, {15'd0, m_active});
    checkOutput("tx_ready", {15'd0, tx_ready}, {15'd0, (m_hold.size() == 0)});
    checkOutput("rx_valid", {15'd0, rx_valid}, {15'd0, m_rx_valid});
    if (m_rx_valid) checkOutput("rx_data", rx_data, m_rx_data);
    checkOutput("underrun", {15'd0, underrun}, {15'd0, m_underrun});
`ifdef SPI_SLAVE_OVERRUN_EN
    checkOutput("rx_overrun", {15'd0, rx_overrun}, {15'd0, m_overrun});
`endif
    if (underrun === 1'b1) u_cnt++;
    if (rx_valid === 1'b1) rv_cnt++;
  end

  // One clock of stimulus; afterwards the model absorbs the events flagged for this edge.
  task automatic applyStimulus();
    logic acc, tv, ls;
    logic [15:0] td;
    int ln;
    acc = m_rx_valid && rx_ready;
    tv  = tx_valid;
    td  = tx_data;
    ls  = lsb_first;
    ln  = int'(len);
    @(posedge clk);
    #1;
    m_underrun = 1'b0;
    if (ev_start) begin
      m_active = 1'b1; m_lsb = ls; m_len = ln; m_overrun = 1'b0; m_bit = 0;
    end else if (ev_stop) begin
      m_active = 1'b0; m_cur = '0; m_bit = 0;
    end
    if (ev_load) begin
      if (m_hold.size() != 0) m_cur = m_hold.pop_front();
      else if (tv)            m_cur = td;
      else begin
        m_cur = '0; m_underrun = 1'b1;
      end
      m_bit = 0;
    end else if (tv && m_hold.size() == 0) begin
      m_hold.push_back(td);
    end
    if (ev_done) begin
      if (m_rx_valid && !acc) m_overrun = 1'b1;
      m_rx_valid = 1'b1;
      m_rx_data  = ev_word;
    end else if (acc) begin
      m_rx_valid = 1'b0;
    end
    ev_start = 0; ev_stop = 0; ev_load = 0; ev_done = 0;
    spi_start = 0; spi_stop = 0; sck_first_edge = 0; sck_second_edge = 0; tx_valid = 0;
  endtask

  task automatic offerTx(input logic [15:0] v);
    tx_valid = 1'b1; tx_data = v;
    applyStimulus();
  endtask

  task automatic startXfer();
    spi_start = 1'b1; ev_start = 1'b1; ev_load = 1'b1;
    applyStimulus();
  endtask

  task automatic stopXfer();
    spi_stop = 1'b1; ev_stop = 1'b1;
    applyStimulus();
  endtask

  task automatic markDone(input logic [15:0] w, input int n);
    logic [15:0] mask;
    mask = (n == 16) ? 16'hFFFF : 16'((32'd1 << n) - 1);
    ev_done = 1'b1; ev_load = 1'b1; ev_word = w & mask;
  endtask

  // Master side: shifts out w (nsend bits), records miso at each read edge into got.
  task automatic sendWord(input logic [15:0] w, input int nsend, input logic offer,
                          input logic [15:0] offer_val, output logic [15:0] got);
    int n, k;
    logic last;
    n = m_len + 1;
    got = '0;
    for (int i = 0; i < nsend; i++) begin
      last = (i == n - 1);
      k = m_lsb ? i : (n - 1 - i);
      mosi = w[k];
      if (!cpha) begin
        got[k] = miso;
        sck_first_edge = 1'b1;
        if (last) markDone(w, n);
        applyStimulus();
        if (offer && i == 0) begin tx_valid = 1'b1; tx_data = offer_val; end
        applyStimulus();
        sck_second_edge = 1'b1;
        applyStimulus();
        if (!last) m_bit = i + 1;
        applyStimulus();
      end else begin
        sck_first_edge = 1'b1;
        applyStimulus();
        if (i != 0) m_bit = i;
        if (offer && i == 0) begin tx_valid = 1'b1; tx_data = offer_val; end
        applyStimulus();
        got[k] = miso;
        sck_second_edge = 1'b1;
        if (last) markDone(w, n);
        applyStimulus();
        applyStimulus();
      end
    end
  endtask

  task automatic modelReset();
    m_active = 0; m_lsb = 0; m_len = 0; m_cur = '0; m_bit = 0;
    m_hold.delete();
    m_rx_data = '0; m_rx_valid = 0; m_underrun = 0; m_overrun = 0;
  endtask

  logic [15:0] got, got2;

  initial begin
    modelReset();
    rst = 1'b1;
    #1;
    checkOutput("reset_miso", {15'd0, miso}, 16'd0);
    checkOutput("reset_tx_ready", {15'd0, tx_ready}, 16'd1);
    checkOutput("reset_rx_valid", {15'd0, rx_valid}, 16'd0);
    checkOutput("reset_busy", {15'd0, busy}, 16'd0);
    checkOutput("reset_underrun", {15'd0, underrun}, 16'd0);
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();

    // cpha=0, MSB-first, 8-bit word
    $display("[TB] case 1: cpha0 msb len7");
    cpha = 0; lsb_first = 0; len = 4'd7; rx_ready = 0;
    offerTx(16'h00A5);
    startXfer();
    sendWord(16'h003C, 8, 1'b0, '0, got);
    checkOutput("c1_miso_seq", got, 16'h00A5);
    applyStimulus();
    checkOutput("c1_rx_valid_held", {15'd0, rx_valid}, 16'd1);
    checkOutput("c1_rx_data", rx_data, 16'h003C);
    rx_ready = 1;
    applyStimulus();
    rx_ready = 0;
    checkOutput("c1_rx_valid_clear", {15'd0, rx_valid}, 16'd0);
    stopXfer();

    // cpha=1, LSB-first, 16-bit word
    $display("[TB] case 2: cpha1 lsb len15");
    cpha = 1; lsb_first = 1; len = 4'd15; rx_ready = 0;
    offerTx(16'h8001);
    startXfer();
    sendWord(16'h1234, 16, 1'b0, '0, got);
    checkOutput("c2_miso_seq", got, 16'h8001);
    checkOutput("c2_rx_data", rx_data, 16'h1234);
    rx_ready = 1;
    applyStimulus();
    stopXfer();

    // Burst of two 4-bit words, second TX word supplied mid-word
    $display("[TB] case 3: burst len3");
    cpha = 0; lsb_first = 0; len = 4'd3; rx_ready = 1;
    offerTx(16'h0009);
    startXfer();
    u_cnt = 0; rv_cnt = 0;
    sendWord(16'h000A, 4, 1'b1, 16'h0006, got);
    checkOutput("c3_underrun_w1", u_cnt[15:0], 16'd0);
    sendWord(16'h0005, 4, 1'b0, '0, got2);
    checkOutput("c3_miso_w1", got, 16'h0009);
    checkOutput("c3_miso_w2", got2, 16'h0006);
    checkOutput("c3_rx_events", rv_cnt[15:0], 16'd2);
    stopXfer();

    // Empty holding register at second word
    $display("[TB] case 4: tx underrun");
    offerTx(16'h000F);
    startXfer();
    u_cnt = 0;
    sendWord(16'h0003, 4, 1'b0, '0, got);
    checkOutput("c4_underrun_pulse", u_cnt[15:0], 16'd1);
    sendWord(16'h000C, 4, 1'b0, '0, got2);
    checkOutput("c4_miso_w1", got, 16'h000F);
    checkOutput("c4_miso_w2", got2, 16'h0000);
    stopXfer();

    // Stop mid-word, then a clean transfer
    $display("[TB] case 5: abort mid-word");
    len = 4'd7; rx_ready = 1;
    applyStimulus();
    offerTx(16'h00FF);
    startXfer();
    sendWord(16'h0099, 5, 1'b0, '0, got);
    stopXfer();
    checkOutput("c5_rx_valid", {15'd0, rx_valid}, 16'd0);
    checkOutput("c5_busy", {15'd0, busy}, 16'd0);
    checkOutput("c5_miso", {15'd0, miso}, 16'd0);
    offerTx(16'h005A);
    startXfer();
    sendWord(16'h00C3, 8, 1'b0, '0, got);
    checkOutput("c5_miso_seq", got, 16'h005A);
    checkOutput("c5_rx_data", rx_data, 16'h00C3);
    stopXfer();

    // Overwrite without acceptance, then async reset mid-word
    $display("[TB] case 6: rx overwrite and reset");
    rx_ready = 0;
    startXfer();
    sendWord(16'h0011, 8, 1'b0, '0, got);
    sendWord(16'h0022, 8, 1'b0, '0, got);
    checkOutput("c6_rx_data", rx_data, 16'h0022);
    checkOutput("c6_rx_valid", {15'd0, rx_valid}, 16'd1);
`ifdef SPI_SLAVE_OVERRUN_EN
    checkOutput("c6_overrun_set", {15'd0, rx_overrun}, 16'd1);
`endif
    startXfer();
`ifdef SPI_SLAVE_OVERRUN_EN
    checkOutput("c6_overrun_clr", {15'd0, rx_overrun}, 16'd0);
`endif
    offerTx(16'h0033);
    sendWord(16'h0077, 3, 1'b0, '0, got);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("c6_rst_miso", {15'd0, miso}, 16'd0);
    checkOutput("c6_rst_busy", {15'd0, busy}, 16'd0);
    checkOutput("c6_rst_rx_valid", {15'd0, rx_valid}, 16'd0);
    checkOutput("c6_rst_rx_data", rx_data, 16'd0);
    checkOutput("c6_rst_tx_ready", {15'd0, tx_ready}, 16'd1);
    checkOutput("c6_rst_underrun", {15'd0, underrun}, 16'd0);
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_slave_datapath_param.md
Name: spi_slave_datapath_param

Overview:
Parametrised SPI slave datapath, the next generation of the fixed-width slave shifter. It adds runtime word length, MSB/LSB-first order, multi-word bursts within one chip-select window, and valid/ready TX/RX handshakes. It sits between the slave edge detector (sck edge strobes, cs start/stop strobes) and the user logic.

Parameters:
SPI_MAX_WIDTH_LOG, 4, log2 of max word width; W = 2**SPI_MAX_WIDTH_LOG.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cpha  in  1  clock phase; sampled live
lsb_first  in  1  bit order; latched at spi_start
len  in  SPI_MAX_WIDTH_LOG  word length minus 1; latched at spi_start
spi_start  in  1  cs-assert strobe, one cycle
spi_stop  in  1  cs-deassert strobe, one cycle
sck_first_edge  in  1  leading sck edge strobe
sck_second_edge  in  1  trailing sck edge strobe
mosi  in  1  serial data in, already synchronised
miso  out  1  serial data out
tx_data  in  W  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX holding register empty
rx_data  out  W  received word, right-justified, upper bits 0
rx_valid  out  1  rx_data valid
rx_ready  in  1  consumer accepts rx_data
busy  out  1  in ACTIVE state
underrun  out  1  one-cycle pulse: word loaded with no TX data

Behaviour:
- Reset (async, rst=1): state IDLE; all registers 0; miso=0, rx_valid=0, busy=0, underrun=0, tx_ready=1.
- States: IDLE -> ACTIVE on spi_start. ACTIVE -> IDLE on spi_stop. spi_start while ACTIVE restarts the transfer. spi_start and spi_stop in the same cycle: start wins.
- Edge roles: cpha=0: read=first edge, write=second edge. cpha=1: read=second edge, write=first edge. Edges are ignored in IDLE. Both edges in one cycle is illegal; only first_edge is processed. start/stop take priority over edges.
- TX holding register: a tx_valid&&tx_ready handshake fills it; tx_ready = ~full.
- Load event (spi_start or word completion): the shifter takes the holding register and empties it. If the register is empty, a word accepted the same cycle is forwarded to the shifter. Otherwise the shifter loads all-zeros and underrun pulses 1 cycle later.
- bit_cnt (0..W): reset to 0 on load.
- Read edge: capture mosi, bit_cnt+1. LSB-first places the bit at index bit_cnt. MSB-first shifts left into bit 0.
- Write edge: shift the TX shifter only if bit_cnt != 0. This suppresses the first cpha=1 write and the write directly after word completion.
- Word completion: the read edge on which bit_cnt reaches len+1.
- miso: ACTIVE and LSB-first -> shifter[0], shifting right. ACTIVE and MSB-first -> shifter[len], shifting left. IDLE -> 0.
- RX: on completion, rx_data is updated and rx_valid=1 on the next cycle. rx_valid holds until rx_valid&&rx_ready, then clears.
- RX overwrite: if a completion occurs while rx_valid=1, the new word overwrites the old and rx_valid stays 1. A completion and an acceptance in the same cycle yields the new word with rx_valid=1.
- spi_stop mid-word: the partial RX word is discarded with no rx_valid, the TX shifter is cleared, and the holding register is kept.
- len/lsb_first changes during ACTIVE have no effect until the next spi_start.

Optional Feature:
SPI_SLAVE_OVERRUN_EN
- Defined: adds output rx_overrun (1 bit). It is sticky, set the cycle after a completion overwrites an unaccepted word, and cleared by spi_start or rst.
- Undefined: the port is absent and overwrite is silent.

Test Plan:
- W=16, len=7, cpha=0, MSB-first; preload tx=0xA5; master sends 0x3C -> miso sequence 1,0,1,0,0,1,0,1; rx_data=0x003C with rx_valid pulse held until rx_ready.
- cpha=1, LSB-first, len=15, tx=0x8001 -> miso 1, then 14x0, then 1. First write edge produces no shift. rx_data equals master word 0x1234.
- Burst: len=3, two 4-bit words in one cs; tx preloaded 0x9 then 0x6 delivered during word 1 -> miso 1001 then 0110 (MSB-first); two rx_valid events; no underrun.
- Empty TX at second word -> miso all 0 for word 2; underrun=1 for exactly 1 cycle at the load.
- spi_stop after 5 of 8 bits -> rx_valid stays 0, busy=0, miso=0. A new spi_start then completes a full 8-bit word correctly.
- rx_ready held 0 across two words 0x11, 0x22 -> rx_data=0x22; with SPI_SLAVE_OVERRUN_EN, rx_overrun=1 until the next spi_start. Assert rst mid-word -> all outputs return to reset values immediately.
